// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with operand capture, registered result/flags and a bit-serial shifter.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int IMM_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_alu_cmd,
  input  logic [IMM_W-1:0] i_immed,
  input  logic             i_direct,
  input  logic             i_move_ctl,
  input  logic [WIDTH-1:0] i_ina,
  input  logic [WIDTH-1:0] i_inb,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_rslt,
  output logic             o_br_logic,
  output logic             o_zero,
  output logic             o_pari,
  output logic             o_carry
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_work, r_rslt, w_res, w_shf, w_nr;
  logic [WIDTH:0]   w_sum;
  logic [IMM_W-1:0] r_cnt;
  logic r_dir, r_carry, r_br, r_zero, r_pari;
  logic w_acc, w_go_shift, w_last, w_load, w_cy, w_br, w_bit, w_nc, w_nb;
  assign o_in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && i_out_ready);
  assign o_out_valid = (r_state == S_DONE);
  assign o_rslt      = r_rslt;
  assign o_carry     = r_carry;
  assign o_br_logic  = r_br;
  assign o_zero      = r_zero;
  assign o_pari      = r_pari;
  always_comb begin
    w_acc      = i_in_valid && o_in_ready;
    w_go_shift = w_acc && i_alu_cmd == 3'b101 && i_immed != '0;
    w_last     = r_state == S_SHIFT && r_cnt == IMM_W'(1);
    w_load     = (w_acc && !w_go_shift) || w_last;
    w_sum      = {1'b0, i_ina} + (WIDTH+1)'(i_immed);
    w_res      = i_alu_cmd <= 3'b001 ? i_inb :
                 i_alu_cmd == 3'b010 ? (i_move_ctl ? w_sum[WIDTH-1:0] : WIDTH'(i_immed)) :
                 i_alu_cmd == 3'b011 ? i_ina ^ i_inb :
                 i_alu_cmd == 3'b100 ? i_ina & i_inb :
                 i_alu_cmd == 3'b101 ? i_ina : '0;
    w_cy       = i_alu_cmd == 3'b010 && i_move_ctl && w_sum[WIDTH];
    w_br       = i_alu_cmd == 3'b110 && i_ina == i_inb;
    w_shf      = r_dir ? {1'b0, r_work[WIDTH-1:1]} : {r_work[WIDTH-2:0], 1'b0};
    w_bit      = r_dir ? r_work[0] : r_work[WIDTH-1];
    w_nr       = r_state == S_SHIFT ? w_shf : w_res;
    w_nc       = r_state == S_SHIFT ? w_bit : w_cy;
    w_nb       = r_state == S_SHIFT ? 1'b0 : w_br;
  end
  always_comb begin
    w_next = r_state;
    if (w_acc)
      w_next = w_go_shift ? S_SHIFT : S_DONE;
    else if (r_state == S_SHIFT)
      w_next = w_last ? S_DONE : S_SHIFT;
    else if (r_state == S_DONE && i_out_ready)
      w_next = S_IDLE;
  end
  // Shift working state is kept apart from the result registers so outputs only move on completion.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rslt  <= '0;
      r_carry <= 1'b0;
      r_br    <= 1'b0;
      r_zero  <= 1'b1;
      r_pari  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go_shift) begin
        r_work <= i_ina;
        r_cnt  <= i_immed;
        r_dir  <= i_direct;
      end else if (r_state == S_SHIFT) begin
        r_work <= w_shf;
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_load) begin
        r_rslt  <= w_nr;
        r_carry <= w_nc;
        r_br    <= w_nb;
        r_zero  <= ~|w_nr;
        r_pari  <= ^w_nr;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, hand-written corner sequences and random ops against a reference model.
module tb_alu_seq;
  localparam int W = 8;
  localparam int IW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 0, direct = 0, move_ctl = 0;
  logic [2:0] alu_cmd = 0;
  logic [IW-1:0] immed = 0;
  logic [W-1:0] ina = 0, inb = 0;
  logic in_ready, out_valid, br_logic, zero, pari, carry;
  logic [W-1:0] rslt;
  logic h_in_valid = 0, h_out_ready = 0, h_direct = 0, h_move_ctl = 0;
  logic [2:0] h_cmd = 0;
  logic [3:0] h_immed = 0;
  logic [15:0] h_ina = 0, h_inb = 0, h_rslt;
  logic h_in_ready, h_out_valid, h_br, h_zero, h_pari, h_carry;
  alu_seq #(.WIDTH(W), .IMM_W(IW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_alu_cmd(alu_cmd), .i_immed(immed), .i_direct(direct), .i_move_ctl(move_ctl),
    .i_ina(ina), .i_inb(inb), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_rslt(rslt), .o_br_logic(br_logic), .o_zero(zero), .o_pari(pari), .o_carry(carry));
  alu_seq #(.WIDTH(16), .IMM_W(4)) dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_in_valid(h_in_valid), .o_in_ready(h_in_ready),
    .i_alu_cmd(h_cmd), .i_immed(h_immed), .i_direct(h_direct), .i_move_ctl(h_move_ctl),
    .i_ina(h_ina), .i_inb(h_inb), .o_out_valid(h_out_valid), .i_out_ready(h_out_ready),
    .o_rslt(h_rslt), .o_br_logic(h_br), .o_zero(h_zero), .o_pari(h_pari), .o_carry(h_carry));
  typedef struct {
    logic [2:0] cmd; logic [IW-1:0] imm; logic dir, mv;
    logic [W-1:0] a, b, r; logic c, br;
  } vec_t;
  vec_t vt[14];
  int n_chk = 0, n_err = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t model(input logic [2:0] cmd, input logic [IW-1:0] imm, input logic dir,
                                 input logic mv, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    int ai, n, s;
    ai = int'(a);
    n = int'(imm);
    v = '{cmd, imm, dir, mv, a, b, '0, 1'b0, 1'b0};
    case (cmd)
      3'd0, 3'd1: v.r = b;
      3'd2: begin
        s = mv ? ai + n : n;
        v.r = W'(s % 256);
        v.c = mv && s > 255;
      end
      3'd3: v.r = a ^ b;
      3'd4: v.r = a & b;
      3'd5: begin
        if (dir) begin
          v.r = W'(ai >> n);
          v.c = n > 0 && (((ai >> (n - 1)) & 1) == 1);
        end else begin
          v.r = W'((ai << n) % 256);
          v.c = n > 0 && ((((ai << (n - 1)) >> 7) & 1) == 1);
        end
      end
      3'd6: v.br = (a == b);
      default: v.r = '0;
    endcase
    return v;
  endfunction
  task automatic run_op(input vec_t v, input int stall);
    int lat, exp_lat;
    logic [W-1:0] held;
    logic moved;
    alu_cmd = v.cmd; immed = v.imm; direct = v.dir; move_ctl = v.mv; ina = v.a; inb = v.b;
    in_valid = 1; out_ready = 0;
    #1;
    chk("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 0;
    alu_cmd = 3'($urandom); immed = IW'($urandom); ina = W'($urandom); inb = W'($urandom);
    direct = 1'($urandom); move_ctl = 1'($urandom);
    exp_lat = v.cmd == 3'd5 ? int'(v.imm) + 1 : 1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) begin
        n_chk++; n_err++;
        $display("FAIL in_ready_busy: got 1 expected 0 at cycle %0d", lat);
      end
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    held = rslt;
    moved = 0;
    for (int i = 0; i < stall; i++) begin
      tick();
      moved |= (rslt !== held) || !out_valid || in_ready;
    end
    if (stall > 0) chk("hold_stable", moved, 0);
    chk("rslt", rslt, v.r);
    chk("carry", carry, v.c);
    chk("br_logic", br_logic, v.br);
    chk("zero", zero, v.r == 0);
    chk("pari", pari, ^v.r);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("consumed", out_valid, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] s_cmd[4];
    logic [W-1:0] s_a[4], s_b[4], s_r[4];
    logic s_br[4];
    logic bad;
    int lat;
    vt[0]  = '{3'd0, 2'd0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h34, 1'b0, 1'b0};
    vt[1]  = '{3'd1, 2'd1, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h55, 1'b0, 1'b0};
    vt[2]  = '{3'd2, 2'd2, 1'b0, 1'b1, 8'hFE, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[3]  = '{3'd2, 2'd3, 1'b0, 1'b1, 8'h10, 8'h77, 8'h13, 1'b0, 1'b0};
    vt[4]  = '{3'd2, 2'd3, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h03, 1'b0, 1'b0};
    vt[5]  = '{3'd3, 2'd0, 1'b0, 1'b0, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0};
    vt[6]  = '{3'd4, 2'd0, 1'b0, 1'b0, 8'hCC, 8'h0F, 8'h0C, 1'b0, 1'b0};
    vt[7]  = '{3'd5, 2'd3, 1'b1, 1'b0, 8'hB5, 8'h00, 8'h16, 1'b1, 1'b0};
    vt[8]  = '{3'd5, 2'd0, 1'b1, 1'b0, 8'hB5, 8'h00, 8'hB5, 1'b0, 1'b0};
    vt[9]  = '{3'd5, 2'd3, 1'b0, 1'b0, 8'h81, 8'h00, 8'h08, 1'b0, 1'b0};
    vt[10] = '{3'd5, 2'd2, 1'b0, 1'b0, 8'h60, 8'h00, 8'h80, 1'b1, 1'b0};
    vt[11] = '{3'd6, 2'd0, 1'b0, 1'b0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    vt[12] = '{3'd6, 2'd0, 1'b0, 1'b0, 8'h05, 8'h06, 8'h00, 1'b0, 1'b0};
    vt[13] = '{3'd7, 2'd1, 1'b0, 1'b1, 8'h07, 8'h07, 8'h00, 1'b0, 1'b0};
    s_cmd = '{3'd6, 3'd6, 3'd4, 3'd2};
    s_a   = '{8'h05, 8'h05, 8'hCC, 8'h00};
    s_b   = '{8'h05, 8'h06, 8'h0F, 8'h00};
    s_r   = '{8'h00, 8'h00, 8'h0C, 8'h03};
    s_br  = '{1'b1, 1'b0, 1'b0, 1'b0};
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rslt", rslt, 0);
    chk("rst_zero", zero, 1);
    chk("rst_flags", {pari, carry, br_logic}, 0);
    rst_n = 1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    foreach (vt[i]) run_op(vt[i], i % 3);
    // Reset in the middle of a shift must discard the operation.
    alu_cmd = 3'd5; immed = 2'd3; direct = 0; ina = 8'h81; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_rslt", rslt, 0);
    chk("midrst_zero", zero, 1);
    tick();
    rst_n = 1;
    tick();
    chk("midrst_in_ready", in_ready, 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bad |= out_valid;
    end
    chk("midrst_no_stale", bad, 0);
    alu_cmd = 3'd3; ina = 8'h0F; inb = 8'hFF; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    chk("bp_valid", out_valid, 1);
    chk("bp_rslt", rslt, 8'hF0);
    chk("bp_pari", pari, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bad |= (rslt !== 8'hF0) || in_ready || !out_valid;
    end
    chk("bp_hold", bad, 0);
    alu_cmd = 3'd4; ina = 8'hCC; inb = 8'h0F; in_valid = 1; out_ready = 1;
    #1;
    chk("bp_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_rslt", rslt, 8'h0C);
    tick();
    out_ready = 0;
    chk("bp_drained", out_valid, 0);
    out_ready = 1; in_valid = 1; move_ctl = 0; immed = 2'd3;
    for (int i = 0; i < 4; i++) begin
      alu_cmd = s_cmd[i]; ina = s_a[i]; inb = s_b[i];
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_rslt", rslt, s_r[i]);
      chk("stream_br", br_logic, s_br[i]);
    end
    in_valid = 0;
    tick();
    out_ready = 0;
    chk("stream_end", out_valid, 0);
    h_cmd = 3'd2; h_move_ctl = 1; h_ina = 16'hFFFF; h_immed = 4'd1; h_in_valid = 1; h_out_ready = 1;
    tick();
    h_in_valid = 0;
    chk("w16_add_valid", h_out_valid, 1);
    chk("w16_add_rslt", h_rslt, 16'h0000);
    chk("w16_add_carry", h_carry, 1);
    tick();
    h_cmd = 3'd5; h_direct = 0; h_ina = 16'h0001; h_immed = 4'd15; h_in_valid = 1; h_out_ready = 0;
    tick();
    h_in_valid = 0;
    lat = 1;
    while (!h_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("w16_shift_lat", lat, 16);
    chk("w16_shift_rslt", h_rslt, 16'h8000);
    chk("w16_shift_carry", h_carry, 0);
    h_out_ready = 1;
    tick();
    h_out_ready = 0;
    for (int k = 0; k < 120; k++)
      run_op(model(3'($urandom_range(0, 7)), IW'($urandom), 1'($urandom), 1'($urandom),
                   W'($urandom), W'($urandom)), $urandom_range(0, 2));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
